// File: rtl/multi_channel_coordinator.sv
// Multi-channel RAM access coordinator: arbitrates NCH requesters onto one DMA port.
// Define COORD_ROUND_ROBIN_EN for round-robin arbitration; otherwise fixed priority (lowest index).
module multi_channel_coordinator #(
  parameter int NCH     = 4,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NCH-1:0]        ch_en_i,
  input  logic [NCH-1:0]        req_i,
  input  logic [NCH-1:0]        we_i,
  input  logic [NCH*ADDR_W-1:0] addr_i,
  input  logic [NCH*DATA_W-1:0] wdata_i,
  output logic [NCH-1:0]        gnt_o,
  output logic [NCH-1:0]        done_o,
  output logic                  err_o,
  output logic [DATA_W-1:0]     rdata_o,
  output logic [ADDR_W-1:0]     ram_addr_o,
  output logic [DATA_W-1:0]     ram_wdata_o,
  output logic                  ram_rd_o,
  output logic                  ram_wr_o,
  input  logic [DATA_W-1:0]     ram_rdata_i,
  input  logic                  ram_done_i,
  output logic                  busy_o
);

  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e              state_q, state_d;
  logic [IW-1:0]       win_q, win_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [7:0]          cnt_inc;
  logic                to_q, to_d;
  logic [NCH-1:0]      cand;
  logic [IW-1:0]       pick;
  logic [ADDR_W-1:0]   addr_arr [NCH];
  logic [DATA_W-1:0]   wdata_arr[NCH];

  assign cand    = req_i & ch_en_i;
  assign cnt_inc = cnt_q + 8'd1;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_unpack
    assign addr_arr[gi]  = addr_i[gi*ADDR_W +: ADDR_W];
    assign wdata_arr[gi] = wdata_i[gi*DATA_W +: DATA_W];
  end

`ifdef COORD_ROUND_ROBIN_EN
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] idx;

  // Scan from the far end back to ptr so the pointer position wins last.
  always_comb begin
    pick = '0;
    idx  = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      idx = IW'((int'(ptr_q) + k) % NCH);
      if (cand[idx]) pick = idx;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (state_q == IDLE && cand != '0) ptr_d = IW'((int'(pick) + 1) % NCH);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end
`else
  always_comb begin
    pick = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (cand[k]) pick = IW'(k);
    end
  end
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      win_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
    end
  end

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    to_d    = to_q;
    unique case (state_q)
      IDLE: begin
        if (cand != '0) begin
          win_d   = pick;
          we_d    = we_i[pick];
          addr_d  = addr_arr[pick];
          wdata_d = wdata_arr[pick];
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        // Completion takes precedence over a timeout landing on the same edge.
        if (ram_done_i) begin
          if (!we_q) rdata_d = ram_rdata_i;
          state_d = RESP;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == TO_LIMIT) begin
            to_d    = 1'b1;
            state_d = RESP;
          end
        end
      end
      RESP: begin
        cnt_d   = '0;
        to_d    = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_o   = (state_q != IDLE);
    ram_rd_o = (state_q == ISSUE) && !we_q;
    ram_wr_o = (state_q == ISSUE) && we_q;
    err_o    = (state_q == RESP) && to_q;
    gnt_o    = '0;
    done_o   = '0;
    for (int k = 0; k < NCH; k++) begin
      gnt_o[k]  = busy_o && (win_q == IW'(k));
      done_o[k] = (state_q == RESP) && (win_q == IW'(k));
    end
  end

  assign rdata_o     = rdata_q;
  assign ram_addr_o  = addr_q;
  assign ram_wdata_o = wdata_q;

endmodule

// File: tb/tb_multi_channel_coordinator.sv
// Directed self-checking bench for multi_channel_coordinator (NCH=4, TIMEOUT=8).
module tb_multi_channel_coordinator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  ch_en, req, we;
  logic [63:0] addr;
  logic [31:0] wdata;
  logic [3:0]  gnt, done;
  logic        err;
  logic [7:0]  rdata;
  logic [15:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic        ram_rd, ram_wr;
  logic [7:0]  ram_rdata;
  logic        ram_done;
  logic        busy;

  int tests = 0;
  int fails = 0;
  logic [3:0] exp_g;

  always #5 clk = ~clk;

  multi_channel_coordinator #(.NCH(4), .ADDR_W(16), .DATA_W(8), .TIMEOUT(8)) dut (
    .clk_i(clk), .rst_ni(rst_n), .ch_en_i(ch_en), .req_i(req), .we_i(we),
    .addr_i(addr), .wdata_i(wdata), .gnt_o(gnt), .done_o(done), .err_o(err),
    .rdata_o(rdata), .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata),
    .ram_rd_o(ram_rd), .ram_wr_o(ram_wr), .ram_rdata_i(ram_rdata),
    .ram_done_i(ram_done), .busy_o(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; ch_en = 4'h0; req = 4'h0; we = 4'h0;
    addr = '0; wdata = '0; ram_rdata = 8'h00; ram_done = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_gnt", gnt, 4'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 4'h0);
    check("rst_err", err, 1'b0);
    check("rst_rdata", rdata, 8'h00);
    check("rst_ram_addr", ram_addr, 16'h0);
    check("rst_strobes", {ram_rd, ram_wr}, 2'b00);
    rst_n = 1'b1;

    // Single read on ch0, DMA answers one cycle after the strobe
    ch_en = 4'hF; req = 4'b0001; we = 4'b0000; addr[15:0] = 16'h0010;
    @(posedge clk); @(negedge clk);
    check("rd_gnt", gnt, 4'b0001);
    check("rd_strobe", {ram_rd, ram_wr}, 2'b10);
    check("rd_addr", ram_addr, 16'h0010);
    check("rd_done_early", done, 4'h0);
    req = 4'b0000;
    @(posedge clk); @(negedge clk);
    check("rd_strobe_single", ram_rd, 1'b0);
    check("rd_done_wait", done, 4'h0);
    ram_done = 1'b1; ram_rdata = 8'hA5;
    @(posedge clk); @(negedge clk);
    check("rd_done", done, 4'b0001);
    check("rd_err", err, 1'b0);
    check("rd_rdata", rdata, 8'hA5);
    check("rd_gnt_resp", gnt, 4'b0001);
    ram_done = 1'b0;
    @(posedge clk); @(negedge clk);
    check("rd_idle_busy", busy, 1'b0);
    check("rd_idle_gnt", gnt, 4'h0);
    check("rd_done_pulse", done, 4'h0);

    // Contention between ch1 and ch3, request held throughout
    req = 4'b1010;
    for (int k = 0; k < 4; k++) begin
`ifdef COORD_ROUND_ROBIN_EN
      exp_g = (k % 2 == 0) ? 4'b0010 : 4'b1000;
`else
      exp_g = 4'b0010;
`endif
      @(posedge clk); @(negedge clk);
      check($sformatf("arb_gnt%0d", k), gnt, exp_g);
      @(posedge clk); @(negedge clk);
      ram_done = 1'b1; ram_rdata = 8'h30 + 8'(k);
      @(posedge clk); @(negedge clk);
      check($sformatf("arb_done%0d", k), done, exp_g);
      check($sformatf("arb_rdata%0d", k), rdata, 8'h30 + 8'(k));
      ram_done = 1'b0;
      @(posedge clk); @(negedge clk);
      check($sformatf("arb_idle%0d", k), busy, 1'b0);
    end
    req = 4'b0000;

    // Disabled channel is ignored until enabled
    req = 4'b0100; ch_en = 4'b1011;
    @(posedge clk); @(negedge clk);
    check("mask_busy", busy, 1'b0);
    check("mask_gnt", gnt, 4'h0);
    ch_en = 4'hF;
    @(posedge clk); @(negedge clk);
    check("mask_gnt2", gnt, 4'b0100);
    req = 4'b0000;
    @(posedge clk); @(negedge clk);
    ram_done = 1'b1; ram_rdata = 8'h5C;
    @(posedge clk); @(negedge clk);
    check("mask_done", done, 4'b0100);
    check("mask_rdata", rdata, 8'h5C);
    ram_done = 1'b0;
    @(posedge clk); @(negedge clk);

    // Write that times out; inputs changed after grant must not leak in
    req = 4'b0001; we = 4'b0001; addr[15:0] = 16'h1234; wdata[7:0] = 8'h77;
    @(posedge clk); @(negedge clk);
    check("wr_strobe", {ram_rd, ram_wr}, 2'b01);
    check("wr_addr", ram_addr, 16'h1234);
    check("wr_wdata", ram_wdata, 8'h77);
    req = 4'b0000; addr[15:0] = 16'hBEEF; wdata[7:0] = 8'h11; ram_rdata = 8'hEE;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); @(negedge clk);
      check($sformatf("to_wait%0d", k), {done, err}, 5'b0);
    end
    @(posedge clk); @(negedge clk);
    check("to_done", done, 4'b0001);
    check("to_err", err, 1'b1);
    check("to_rdata", rdata, 8'h5C);
    check("to_addr_held", ram_addr, 16'h1234);
    check("to_wdata_held", ram_wdata, 8'h77);
    @(posedge clk); @(negedge clk);
    check("to_err_pulse", err, 1'b0);
    check("to_idle", busy, 1'b0);

    // Completion on the same edge the counter reaches the limit is a success
    req = 4'b0001; we = 4'b0000;
    @(posedge clk); @(negedge clk);
    req = 4'b0000;
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("edge_no_done_yet", done, 4'h0);
    ram_done = 1'b1; ram_rdata = 8'hC3;
    @(posedge clk); @(negedge clk);
    check("edge_done", done, 4'b0001);
    check("edge_err", err, 1'b0);
    check("edge_rdata", rdata, 8'hC3);
    ram_done = 1'b0;
    @(posedge clk); @(negedge clk);

    // Reset during WAIT aborts silently
    req = 4'b0001;
    @(posedge clk); @(negedge clk);
    req = 4'b0000;
    @(posedge clk); @(negedge clk);
    check("abort_busy_pre", busy, 1'b1);
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    check("abort_busy", busy, 1'b0);
    check("abort_gnt", gnt, 4'h0);
    check("abort_done", {done, err}, 5'b0);
    check("abort_rdata", rdata, 8'h00);
    check("abort_ram_addr", ram_addr, 16'h0);
    rst_n = 1'b1;
    req = 4'b0100; addr[47:32] = 16'h0042;
    @(posedge clk); @(negedge clk);
    check("post_gnt", gnt, 4'b0100);
    check("post_addr", ram_addr, 16'h0042);
    req = 4'b0000;
    @(posedge clk); @(negedge clk);
    ram_done = 1'b1; ram_rdata = 8'h3E;
    @(posedge clk); @(negedge clk);
    check("post_done", done, 4'b0100);
    check("post_rdata", rdata, 8'h3E);
    ram_done = 1'b0;
    @(posedge clk); @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multi_channel_coordinator.md
MULTI_CHANNEL_COORDINATOR -- requirements
Module: multi_channel_coordinator

Interface
REQ-001 Parameter NCH, 4, number of RAM requester channels (2..8) SHALL be supported.
REQ-002 Parameter ADDR_W, 16, RAM address width.
REQ-003 Parameter DATA_W, 8, RAM data width.
REQ-004 Parameter TIMEOUT, 64, maximum WAIT cycles before abort (1..255).
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 RST  in  1  synchronous, active-low reset.
REQ-007 ch_en  in  NCH  per-channel enable mask (replaces load/cnn mode selects).
REQ-008 req  in  NCH  per-channel access request, level.
REQ-009 we  in  NCH  per-channel write flag (1 = write, 0 = read).
REQ-010 addr  in  NCH*ADDR_W  per-channel address, channel i at bits [i*ADDR_W +: ADDR_W].
REQ-011 wdata  in  NCH*DATA_W  per-channel write data, same packing.
REQ-012 gnt  out  NCH  one-hot grant, high for the whole transaction.
REQ-013 done  out  NCH  one-cycle completion pulse to the granted channel.
REQ-014 err  out  1  one-cycle pulse with done when the transaction timed out.
REQ-015 rdata  out  DATA_W  read data, valid in the done cycle, held until next completion.
REQ-016 ram_addr / ram_wdata  out  ADDR_W / DATA_W  latched address/data to DMA.
REQ-017 ram_rd / ram_wr  out  1  one-cycle DMA strobes.
REQ-018 ram_rdata  in  DATA_W  DMA read data; ram_done  in  1  DMA completion.
REQ-019 busy  out  1  high in every state except IDLE.

Function
REQ-020 FSM SHALL have states IDLE, ISSUE, WAIT, RESP.
REQ-021 IDLE: if (req & ch_en) != 0, select winner, latch its we/addr/wdata, set gnt[winner], go ISSUE; else stay.
REQ-022 ISSUE: ram_rd = !we_latched, ram_wr = we_latched for exactly this cycle; go WAIT; ram_done ignored here.
REQ-023 WAIT: ram_done=1 -> capture ram_rdata (reads only) into rdata, go RESP; else increment counter; counter reaching TIMEOUT -> set timeout flag, go RESP.
REQ-024 RESP: pulse done[winner], pulse err if timeout flag, clear gnt, counter, flag; go IDLE.
REQ-025 Minimum latency: req sampled at edge N -> done high in cycle N+3; next grant no earlier than N+4.
REQ-026 Requests deasserted before grant SHALL be ignored; req/ch_en changes after grant SHALL NOT abort the transaction.
REQ-027 Channel inputs are latched at grant; later addr/wdata changes SHALL NOT affect the transaction.
REQ-028 Write transactions SHALL leave rdata unchanged; timed-out reads SHALL leave rdata unchanged.
REQ-029 ram_done arriving on the same edge as counter==TIMEOUT SHALL count as success (err=0).

Reset
REQ-030 RST=0 at a clock edge SHALL force IDLE, gnt=0, done=0, err=0, ram_rd=ram_wr=0, busy=0, rdata=0, ram_addr=0, ram_wdata=0, counter=0, RR pointer=0.
REQ-031 Reset mid-transaction SHALL abort it with no done/err pulse.

Configuration
REQ-032 Macro COORD_ROUND_ROBIN_EN defined: round-robin arbitration; pointer p (reset 0) has highest priority, search p, p+1, ... wrapping at NCH; after grant to i, p = (i+1) mod NCH.
REQ-033 Macro undefined: fixed priority, lowest enabled requesting index wins; no pointer register.

Verification
REQ-034 NCH=4, ch_en=4'hF, req=4'b0001 read addr 0x0010, ram_done one cycle after strobe with ram_rdata 0xA5 -> gnt=0001, ram_rd single pulse, done[0] at N+3, rdata=0xA5, err=0.
REQ-035 req=4'b1010 held, ch_en=4'hF -> fixed: four grants all to ch1; RR: grants ch1, ch3, ch1, ch3.
REQ-036 req=4'b0100, ch_en=4'b1011 -> no grant, busy=0; enable ch2 -> grant ch2 next edge.
REQ-037 TIMEOUT=8, write with ram_done never asserted -> WAIT 8 cycles, done and err pulse together, rdata unchanged.
REQ-038 RST=0 during WAIT -> next cycle all outputs at reset values, no done pulse; fresh request afterwards completes normally.
